// File: rtl/ysyx_23060332_idu_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060332_idu_stage
//  Brief    : Registered RV32I/RV64I decode stage with valid/ready handshake,
//             flush, and registered trap/illegal flags.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060332_idu_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        inst_i,
    input  logic [XLEN-1:0]    inst_addr,
    output logic [4:0]         raddr1,
    output logic [4:0]         raddr2,
    input  logic [XLEN-1:0]    rdata1,
    input  logic [XLEN-1:0]    rdata2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    op1,
    output logic [XLEN-1:0]    op2,
    output logic [XLEN-1:0]    op1_jump,
    output logic [XLEN-1:0]    op2_jump,
    output logic [XLEN-1:0]    rs2_data,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_wen,
    output logic [4:0]         waddr,
    output logic               mem_ren,
    output logic               mem_wen,
    output logic [2:0]         mem_size,
    output logic               is_branch,
    output logic               is_jump,
    output logic               trap,
    output logic               illegal,
    output logic [31:0]        inst_o,
    output logic [XLEN-1:0]    pc_o
);

    localparam logic c_is_rv64 = (XLEN == 64);

    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_opimm32 = 7'b0011011;
    localparam logic [6:0] c_opc_op32   = 7'b0111011;
    localparam logic [6:0] c_opc_fence  = 7'b0001111;
    localparam logic [6:0] c_opc_system = 7'b1110011;

    localparam logic [31:0] c_inst_ebreak = 32'h0010_0073;
    localparam logic [31:0] c_inst_ecall  = 32'h0000_0073;

    localparam logic [ALUOP_W-1:0] c_alu_add  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] c_alu_sub  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] c_alu_sll  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] c_alu_slt  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] c_alu_sltu = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] c_alu_xor  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] c_alu_srl  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] c_alu_sra  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] c_alu_or   = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] c_alu_and  = ALUOP_W'(9);

    // Base func3 -> ALU op; SUB/SRA are patched in by the caller from func7.
    function automatic logic [ALUOP_W-1:0] f_alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'd0:    return c_alu_add;
            3'd1:    return c_alu_sll;
            3'd2:    return c_alu_slt;
            3'd3:    return c_alu_sltu;
            3'd4:    return c_alu_xor;
            3'd5:    return c_alu_srl;
            3'd6:    return c_alu_or;
            default: return c_alu_and;
        endcase
    endfunction

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i32, w_imm_s32, w_imm_b32, w_imm_u32, w_imm_j32;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_opcode = inst_i[6:0];
    assign w_f3     = inst_i[14:12];
    assign w_f7     = inst_i[31:25];

    assign w_imm_i32 = {{20{inst_i[31]}}, inst_i[31:20]};
    assign w_imm_s32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign w_imm_b32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign w_imm_u32 = {inst_i[31:12], 12'b0};
    assign w_imm_j32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    assign w_imm_i = XLEN'($signed(w_imm_i32));
    assign w_imm_s = XLEN'($signed(w_imm_s32));
    assign w_imm_b = XLEN'($signed(w_imm_b32));
    assign w_imm_u = XLEN'($signed(w_imm_u32));
    assign w_imm_j = XLEN'($signed(w_imm_j32));

    logic               w_legal, w_use_rs1, w_use_rs2;
    logic [XLEN-1:0]    w_op1, w_op2, w_op1_jump, w_op2_jump, w_rs2_data;
    logic [ALUOP_W-1:0] w_alu_op;
    logic               w_reg_wen, w_mem_ren, w_mem_wen, w_is_branch, w_is_jump, w_trap;
    logic [2:0]         w_mem_size;
    logic [4:0]         w_waddr;

    always_comb begin
        w_legal     = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_op1       = '0;
        w_op2       = '0;
        w_op1_jump  = '0;
        w_op2_jump  = '0;
        w_alu_op    = c_alu_add;
        w_reg_wen   = 1'b0;
        w_mem_ren   = 1'b0;
        w_mem_wen   = 1'b0;
        w_mem_size  = 3'd0;
        w_is_branch = 1'b0;
        w_is_jump   = 1'b0;
        w_trap      = 1'b0;

        case (w_opcode)
            c_opc_lui: begin
                w_legal   = 1'b1;
                w_reg_wen = 1'b1;
                w_op1     = w_imm_u;
            end
            c_opc_auipc: begin
                w_legal   = 1'b1;
                w_reg_wen = 1'b1;
                w_op1     = inst_addr;
                w_op2     = w_imm_u;
            end
            c_opc_jal: begin
                w_legal    = 1'b1;
                w_reg_wen  = 1'b1;
                w_is_jump  = 1'b1;
                w_op1      = inst_addr;
                w_op2      = XLEN'(4);
                w_op1_jump = inst_addr;
                w_op2_jump = w_imm_j;
            end
            c_opc_jalr: begin
                w_use_rs1  = 1'b1;
                w_legal    = (w_f3 == 3'd0);
                w_reg_wen  = 1'b1;
                w_is_jump  = 1'b1;
                w_op1      = inst_addr;
                w_op2      = XLEN'(4);
                w_op1_jump = rdata1;
                w_op2_jump = w_imm_i;
            end
            c_opc_branch: begin
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_legal     = (w_f3 != 3'd2) && (w_f3 != 3'd3);
                w_is_branch = 1'b1;
                w_alu_op    = c_alu_sub;
                w_op1       = rdata1;
                w_op2       = rdata2;
                w_op1_jump  = inst_addr;
                w_op2_jump  = w_imm_b;
            end
            c_opc_load: begin
                w_use_rs1  = 1'b1;
                w_legal    = (w_f3 == 3'd0) || (w_f3 == 3'd1) || (w_f3 == 3'd2) ||
                             (w_f3 == 3'd4) || (w_f3 == 3'd5) ||
                             (c_is_rv64 && ((w_f3 == 3'd3) || (w_f3 == 3'd6)));
                w_mem_ren  = 1'b1;
                w_reg_wen  = 1'b1;
                w_mem_size = w_f3;
                w_op1      = rdata1;
                w_op2      = w_imm_i;
            end
            c_opc_store: begin
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
                w_legal    = (w_f3 == 3'd0) || (w_f3 == 3'd1) || (w_f3 == 3'd2) ||
                             (c_is_rv64 && (w_f3 == 3'd3));
                w_mem_wen  = 1'b1;
                w_mem_size = w_f3;
                w_op1      = rdata1;
                w_op2      = w_imm_s;
            end
            c_opc_opimm: begin
                w_use_rs1 = 1'b1;
                w_reg_wen = 1'b1;
                w_op1     = rdata1;
                w_op2     = w_imm_i;
                w_alu_op  = f_alu_from_f3(w_f3);
                // Shift amounts above 31 only exist on RV64.
                case (w_f3)
                    3'd1:    w_legal = (inst_i[31:26] == 6'd0) && (c_is_rv64 || !inst_i[25]);
                    3'd5: begin
                        w_legal = !inst_i[31] && (inst_i[29:26] == 4'd0) && (c_is_rv64 || !inst_i[25]);
                        if (inst_i[30]) w_alu_op = c_alu_sra;
                    end
                    default: w_legal = 1'b1;
                endcase
            end
            c_opc_opimm32: begin
                w_use_rs1 = 1'b1;
                w_reg_wen = 1'b1;
                w_op1     = rdata1;
                w_op2     = w_imm_i;
                w_alu_op  = f_alu_from_f3(w_f3);
                case (w_f3)
                    3'd0:    w_legal = c_is_rv64;
                    3'd1:    w_legal = c_is_rv64 && (w_f7 == 7'b0000000);
                    3'd5: begin
                        w_legal = c_is_rv64 && ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000));
                        if (w_f7[5]) w_alu_op = c_alu_sra;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            c_opc_op, c_opc_op32: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_reg_wen = 1'b1;
                w_op1     = rdata1;
                w_op2     = rdata2;
                w_alu_op  = f_alu_from_f3(w_f3);
                if (w_f7 == 7'b0100000) begin
                    w_legal  = (w_f3 == 3'd0) || (w_f3 == 3'd5);
                    w_alu_op = (w_f3 == 3'd0) ? c_alu_sub : c_alu_sra;
                end else begin
                    w_legal = (w_f7 == 7'b0000000);
                end
                if (w_opcode == c_opc_op32) begin
                    w_legal = w_legal && c_is_rv64 &&
                              ((w_f3 == 3'd0) || (w_f3 == 3'd1) || (w_f3 == 3'd5));
                end
            end
            c_opc_fence: w_legal = 1'b1;
            c_opc_system: begin
                w_legal = (inst_i == c_inst_ebreak) || (inst_i == c_inst_ecall);
                w_trap  = (inst_i == c_inst_ebreak);
            end
            default: w_legal = 1'b0;
        endcase

        // Illegal instructions flow down the pipe with every side effect suppressed.
        if (!w_legal) begin
            w_op1       = '0;
            w_op2       = '0;
            w_op1_jump  = '0;
            w_op2_jump  = '0;
            w_alu_op    = c_alu_add;
            w_reg_wen   = 1'b0;
            w_mem_ren   = 1'b0;
            w_mem_wen   = 1'b0;
            w_mem_size  = 3'd0;
            w_is_branch = 1'b0;
            w_is_jump   = 1'b0;
            w_trap      = 1'b0;
        end
    end

    assign raddr1     = w_use_rs1 ? inst_i[19:15] : 5'd0;
    assign raddr2     = w_use_rs2 ? inst_i[24:20] : 5'd0;
    assign w_rs2_data = (w_use_rs2 && w_legal) ? rdata2 : '0;
    assign w_waddr    = w_reg_wen ? inst_i[11:7] : 5'd0;

    logic w_accept;
    logic r_out_valid;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    logic [XLEN-1:0]    r_op1, r_op2, r_op1_jump, r_op2_jump, r_rs2_data, r_pc;
    logic [ALUOP_W-1:0] r_alu_op;
    logic               r_reg_wen, r_mem_ren, r_mem_wen, r_is_branch, r_is_jump, r_trap, r_illegal;
    logic [4:0]         r_waddr;
    logic [2:0]         r_mem_size;
    logic [31:0]        r_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_op1_jump  <= '0;
            r_op2_jump  <= '0;
            r_rs2_data  <= '0;
            r_pc        <= '0;
            r_alu_op    <= '0;
            r_reg_wen   <= 1'b0;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_is_branch <= 1'b0;
            r_is_jump   <= 1'b0;
            r_trap      <= 1'b0;
            r_illegal   <= 1'b0;
            r_waddr     <= 5'd0;
            r_mem_size  <= 3'd0;
            r_inst      <= 32'd0;
        end else begin
            if (flush)         r_out_valid <= 1'b0;
            else if (w_accept) r_out_valid <= 1'b1;
            else if (out_ready) r_out_valid <= 1'b0;

            // A flushed instruction is dropped, so the payload keeps its last value.
            if (w_accept && !flush) begin
                r_op1       <= w_op1;
                r_op2       <= w_op2;
                r_op1_jump  <= w_op1_jump;
                r_op2_jump  <= w_op2_jump;
                r_rs2_data  <= w_rs2_data;
                r_pc        <= inst_addr;
                r_alu_op    <= w_alu_op;
                r_reg_wen   <= w_reg_wen;
                r_mem_ren   <= w_mem_ren;
                r_mem_wen   <= w_mem_wen;
                r_is_branch <= w_is_branch;
                r_is_jump   <= w_is_jump;
                r_trap      <= w_trap;
                r_illegal   <= !w_legal;
                r_waddr     <= w_waddr;
                r_mem_size  <= w_mem_size;
                r_inst      <= inst_i;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign op1       = r_op1;
    assign op2       = r_op2;
    assign op1_jump  = r_op1_jump;
    assign op2_jump  = r_op2_jump;
    assign rs2_data  = r_rs2_data;
    assign alu_op    = r_alu_op;
    assign reg_wen   = r_reg_wen;
    assign waddr     = r_waddr;
    assign mem_ren   = r_mem_ren;
    assign mem_wen   = r_mem_wen;
    assign mem_size  = r_mem_size;
    assign is_branch = r_is_branch;
    assign is_jump   = r_is_jump;
    assign trap      = r_trap;
    assign illegal   = r_illegal;
    assign inst_o    = r_inst;
    assign pc_o      = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060332_idu_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_23060332_idu_stage
//  Brief    : Directed-vector bench for the decode stage (XLEN=32 and XLEN=64).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060332_idu_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] inst_i, inst_addr, rdata1, rdata2;
    logic        in_ready, out_valid, reg_wen, mem_ren, mem_wen, is_branch, is_jump, trap, illegal;
    logic [4:0]  raddr1, raddr2, waddr;
    logic [31:0] op1, op2, op1_jump, op2_jump, rs2_data, inst_o, pc_o;
    logic [3:0]  alu_op;
    logic [2:0]  mem_size;

    ysyx_23060332_idu_stage #(.XLEN(32), .ALUOP_W(4)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst_i(inst_i), .inst_addr(inst_addr), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .op1_jump(op1_jump), .op2_jump(op2_jump), .rs2_data(rs2_data),
        .alu_op(alu_op), .reg_wen(reg_wen), .waddr(waddr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_size(mem_size), .is_branch(is_branch), .is_jump(is_jump), .trap(trap),
        .illegal(illegal), .inst_o(inst_o), .pc_o(pc_o)
    );

    logic        in_valid64;
    logic [31:0] inst64;
    logic [63:0] pc64, rdata1_64, rdata2_64;
    logic        in_ready64, out_valid64, reg_wen64, mem_ren64, mem_wen64, is_branch64, is_jump64, trap64, illegal64;
    logic [4:0]  raddr1_64, raddr2_64, waddr64;
    logic [63:0] op1_64, op2_64, op1_jump64, op2_jump64, rs2_data64, pc_o64;
    logic [31:0] inst_o64;
    logic [3:0]  alu_op64;
    logic [2:0]  mem_size64;

    ysyx_23060332_idu_stage #(.XLEN(64), .ALUOP_W(4)) u_dut64 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid64), .in_ready(in_ready64),
        .inst_i(inst64), .inst_addr(pc64), .raddr1(raddr1_64), .raddr2(raddr2_64),
        .rdata1(rdata1_64), .rdata2(rdata2_64), .out_valid(out_valid64), .out_ready(1'b1),
        .op1(op1_64), .op2(op2_64), .op1_jump(op1_jump64), .op2_jump(op2_jump64), .rs2_data(rs2_data64),
        .alu_op(alu_op64), .reg_wen(reg_wen64), .waddr(waddr64), .mem_ren(mem_ren64), .mem_wen(mem_wen64),
        .mem_size(mem_size64), .is_branch(is_branch64), .is_jump(is_jump64), .trap(trap64),
        .illegal(illegal64), .inst_o(inst_o64), .pc_o(pc_o64)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc,
                           input logic [31:0] d1, input logic [31:0] d2);
        in_valid  = 1'b1;
        inst_i    = inst;
        inst_addr = pc;
        rdata1    = d1;
        rdata2    = d2;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        inst_i = 32'h0; inst_addr = 32'h0; rdata1 = 32'h0; rdata2 = 32'h0;
        in_valid64 = 1'b0; inst64 = 32'h0; pc64 = 64'h0; rdata1_64 = 64'h0; rdata2_64 = 64'h0;
        step();
        step();
        rst = 1'b0;
        #1;
        check_val("reset out_valid", out_valid, 0);
        check_val("reset in_ready", in_ready, 1);
        check_val("reset op1", op1, 0);
        check_val("reset illegal", illegal, 0);

        // addi x1,x2,-1
        present(32'hFFF10093, 32'h0000_1000, 32'd5, 32'd0);
        #1;
        check_val("addi raddr1", raddr1, 2);
        check_val("addi raddr2", raddr2, 0);
        step();
        check_val("addi out_valid", out_valid, 1);
        check_val("addi op1", op1, 5);
        check_val("addi op2", op2, 32'hFFFF_FFFF);
        check_val("addi waddr", waddr, 1);
        check_val("addi reg_wen", reg_wen, 1);
        check_val("addi alu_op", alu_op, 0);

        // jal x1,+8
        present(32'h008000EF, 32'h8000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        #1;
        check_val("jal raddr1", raddr1, 0);
        check_val("jal raddr2", raddr2, 0);
        step();
        check_val("jal op1", op1, 32'h8000_0000);
        check_val("jal op2", op2, 4);
        check_val("jal op1_jump", op1_jump, 32'h8000_0000);
        check_val("jal op2_jump", op2_jump, 8);
        check_val("jal is_jump", is_jump, 1);
        check_val("jal pc_o", pc_o, 32'h8000_0000);

        // add x3,x1,x2 then hold 3 cycles while sub waits
        present(32'h002081B3, 32'h0000_2000, 32'd7, 32'd9);
        step();
        check_val("add op1", op1, 7);
        check_val("add op2", op2, 9);
        check_val("add waddr", waddr, 3);
        out_ready = 1'b0;
        present(32'h407302B3, 32'h0000_2004, 32'd100, 32'd1);
        #1;
        check_val("sub raddr1", raddr1, 6);
        check_val("sub raddr2", raddr2, 7);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("hold in_ready", in_ready, 0);
            check_val("hold out_valid", out_valid, 1);
            check_val("hold op1", op1, 7);
            check_val("hold inst_o", inst_o, 32'h002081B3);
        end
        out_ready = 1'b1;
        #1;
        check_val("release in_ready", in_ready, 1);
        step();
        check_val("sub op1", op1, 100);
        check_val("sub op2", op2, 1);
        check_val("sub alu_op", alu_op, 1);
        check_val("sub waddr", waddr, 5);

        // sw x2,4(x1), then flush while held
        present(32'h0020A223, 32'h0000_3000, 32'h0000_0100, 32'h1234_5678);
        step();
        check_val("sw mem_wen", mem_wen, 1);
        check_val("sw op1", op1, 32'h100);
        check_val("sw op2", op2, 4);
        check_val("sw rs2_data", rs2_data, 32'h1234_5678);
        check_val("sw reg_wen", reg_wen, 0);
        check_val("sw mem_size", mem_size, 2);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        #1;
        check_val("flush in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        check_val("flush out_valid", out_valid, 0);
        check_val("flush in_ready after", in_ready, 1);
        step();
        check_val("flush stays invalid", out_valid, 0);

        // flush wins over a simultaneous accept
        out_ready = 1'b1;
        present(32'hFFF10093, 32'h0000_4000, 32'd5, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("flush+accept out_valid", out_valid, 0);

        // illegal all-zero word, then ebreak
        present(32'h0000_0000, 32'h0000_5000, 32'd1, 32'd1);
        step();
        check_val("zero illegal", illegal, 1);
        check_val("zero reg_wen", reg_wen, 0);
        check_val("zero out_valid", out_valid, 1);
        present(32'h0010_0073, 32'h0000_5004, 32'd1, 32'd1);
        step();
        check_val("ebreak trap", trap, 1);
        check_val("ebreak illegal", illegal, 0);
        check_val("ebreak reg_wen", reg_wen, 0);

        // beq x1,x2,+16
        present(32'h0020_8863, 32'h0000_0100, 32'd3, 32'd3);
        step();
        check_val("beq is_branch", is_branch, 1);
        check_val("beq op1_jump", op1_jump, 32'h100);
        check_val("beq op2_jump", op2_jump, 16);
        check_val("beq alu_op", alu_op, 1);
        check_val("beq waddr", waddr, 0);

        // lui x5,0x80000
        present(32'h8000_02B7, 32'h0000_0200, 32'd0, 32'd0);
        #1;
        check_val("lui raddr1", raddr1, 0);
        step();
        check_val("lui op1", op1, 32'h8000_0000);
        check_val("lui op2", op2, 0);
        check_val("lui waddr", waddr, 5);

        // RV64-only encodings on the 32-bit instance
        present(32'h0201_1093, 32'h0000_0204, 32'd0, 32'd0);
        step();
        check_val("slli shamt32 illegal", illegal, 1);
        present(32'h0010_809B, 32'h0000_0208, 32'd0, 32'd0);
        step();
        check_val("addiw rv32 illegal", illegal, 1);

        // addiw x1,x1,1 on XLEN=64
        in_valid64 = 1'b1; inst64 = 32'h0010_809B; pc64 = 64'h8000_0000; rdata1_64 = 64'h1_0000_0000;
        #1;
        check_val("rv64 addiw raddr1", raddr1_64, 1);
        step();
        in_valid64 = 1'b0;
        check_val("rv64 addiw op2", op2_64, 1);
        check_val("rv64 addiw op1", op1_64, 64'h1_0000_0000);
        check_val("rv64 addiw illegal", illegal64, 0);
        check_val("rv64 addiw reg_wen", reg_wen64, 1);

        // reset while holding
        out_ready = 1'b1;
        present(32'hFFF10093, 32'h0000_6000, 32'd5, 32'd0);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        check_val("prehold out_valid", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst out_valid", out_valid, 0);
        check_val("rst op1", op1, 0);
        check_val("rst op2", op2, 0);
        check_val("rst reg_wen", reg_wen, 0);
        check_val("rst waddr", waddr, 0);
        check_val("rst inst_o", inst_o, 0);
        check_val("rst pc_o", pc_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
